// File: rtl/mult_div_pkg.sv
// Shared definitions for the multicycle multiply/divide sequencer:
// state encoding, iteration count and operation select.
package mult_div_pkg;

    localparam int unsigned ITER = 32;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StMult = 3'd1,
        StDiv  = 3'd2,
        StFix  = 3'd3,
        StDone = 3'd4
    } stateT;

    typedef enum logic {
        OpMult = 1'b0,
        OpDiv  = 1'b1
    } opT;

    // 33-bit magnitude so that |0x80000000| stays exact.
    function automatic logic [32:0] magnitude(input logic [31:0] x);
        logic [32:0] ext;
        ext = {x[31], x};
        return x[31] ? (~ext + 33'd1) : ext;
    endfunction

endpackage

// File: rtl/mult_div_ctrl.sv
// Iterative signed 32x32 multiply and 32/32 divide owning HI/LO; one bit per
// cycle, sign fix-up in a dedicated cycle, registered handshake outputs.
module mult_div_ctrl #(
    parameter int unsigned ITER = mult_div_pkg::ITER
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    import mult_div_pkg::*;

    stateT       stateQ, stateD;
    opT          opQ, opD;
    logic        signQ, signD;
    logic        remSignQ, remSignD;
    logic [4:0]  cntQ, cntD;
    logic [63:0] opAQ, opAD;
    logic [32:0] opBQ, opBD;
    logic [63:0] accQ, accD;
    logic [31:0] hiQ, hiD, loQ, loD;
    logic        busyQ, busyD, doneQ, doneD, divZeroQ, divZeroD;

    logic [32:0] magA, magB;
    logic [31:0] trial;
    logic        fits;
    logic [63:0] product;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ   <= StIdle;
            opQ      <= OpMult;
            signQ    <= 1'b0;
            remSignQ <= 1'b0;
            cntQ     <= '0;
            opAQ     <= '0;
            opBQ     <= '0;
            accQ     <= '0;
            hiQ      <= '0;
            loQ      <= '0;
            busyQ    <= 1'b0;
            doneQ    <= 1'b0;
            divZeroQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            opQ      <= opD;
            signQ    <= signD;
            remSignQ <= remSignD;
            cntQ     <= cntD;
            opAQ     <= opAD;
            opBQ     <= opBD;
            accQ     <= accD;
            hiQ      <= hiD;
            loQ      <= loD;
            busyQ    <= busyD;
            doneQ    <= doneD;
            divZeroQ <= divZeroD;
        end
    end

    always_comb begin
        stateD   = stateQ;
        opD      = opQ;
        signD    = signQ;
        remSignD = remSignQ;
        cntD     = cntQ;
        opAD     = opAQ;
        opBD     = opBQ;
        accD     = accQ;
        hiD      = hiQ;
        loD      = loQ;
        divZeroD = 1'b0;

        magA    = magnitude(a);
        magB    = magnitude(b);
        // Divide: accQ holds {remainder, dividend/quotient}; shift one bit into the remainder.
        fits    = accQ[63:31] >= opBQ;
        trial   = 32'(accQ[63:31] - opBQ);
        product = signQ ? (~accQ + 64'd1) : accQ;

        case (stateQ)
            StIdle: begin
                if (start_mult) begin
                    opD   = OpMult;
                    signD = a[31] ^ b[31];
                    opAD  = {31'd0, magA};
                    opBD  = magB;
                    accD  = '0;
                    cntD  = 5'(ITER - 1);
                    stateD = StMult;
                end else if (start_div) begin
                    if (b == 32'd0) begin
                        divZeroD = 1'b1;
                    end else begin
                        opD      = OpDiv;
                        signD    = a[31] ^ b[31];
                        remSignD = a[31];
                        opBD     = magB;
                        accD     = {32'd0, magA[31:0]};
                        cntD     = 5'(ITER - 1);
                        stateD   = StDiv;
                    end
                end
            end
            StMult: begin
                if (opBQ[0]) accD = accQ + opAQ;
                opAD = opAQ << 1;
                opBD = opBQ >> 1;
                cntD = cntQ - 5'd1;
                if (cntQ == 5'd0) stateD = StFix;
            end
            StDiv: begin
                accD = fits ? {trial, accQ[30:0], 1'b1} : {accQ[62:0], 1'b0};
                cntD = cntQ - 5'd1;
                if (cntQ == 5'd0) stateD = StFix;
            end
            StFix: begin
                if (opQ == OpMult) begin
                    hiD = product[63:32];
                    loD = product[31:0];
                end else begin
                    loD = signQ    ? (32'd0 - accQ[31:0])  : accQ[31:0];
                    hiD = remSignQ ? (32'd0 - accQ[63:32]) : accQ[63:32];
                end
                stateD = StDone;
            end
            StDone:  stateD = StIdle;
            default: stateD = StIdle;
        endcase

        busyD = (stateD == StMult) || (stateD == StDiv) || (stateD == StFix);
        doneD = (stateD == StDone);
    end

    assign busy     = busyQ;
    assign done     = doneQ;
    assign div_zero = divZeroQ;
    assign hi       = hiQ;
    assign lo       = loQ;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard bench for mult_div_ctrl: the driver queues expected events, a
// negedge monitor pops and checks them whenever done or div_zero appears.
module tb_mult_div_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startMult = 1'b0;
    logic        startDiv = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, divZero;
    logic [31:0] hi, lo;

    mult_div_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start_mult(startMult),
        .start_div (startDiv),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .div_zero  (divZero),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          isZero;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } expT;

    expT sb[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done || divZero) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: done=%b div_zero=%b cycle %0d", done, divZero, cyc);
            end else begin
                expT e;
                e = sb.pop_front();
                chk("event_kind", {62'd0, done, divZero}, e.isZero ? 64'd1 : 64'd2);
                chk("event_cycle", 64'(cyc), 64'(e.cyc));
                chk("hi", {32'd0, hi}, {32'd0, e.hi});
                chk("lo", {32'd0, lo}, {32'd0, e.lo});
            end
        end
    end

    // pokeAt: cycle after the start edge at which to interfere (0 = never);
    // pokeReset selects reset instead of a stray start_div.
    task automatic runOp(input bit doMult, input bit doDiv, input logic [31:0] opA,
                         input logic [31:0] opB, input logic [31:0] expHi,
                         input logic [31:0] expLo, input int pokeAt, input bit pokeReset);
        expT e;
        int  busyCnt;
        int  n;
        bit  aborted;
        e.isZero = doDiv && !doMult && (opB == 32'd0);
        e.hi     = expHi;
        e.lo     = expLo;
        e.cyc    = cyc + (e.isZero ? 1 : 34);
        sb.push_back(e);
        a = opA;
        b = opB;
        startMult = doMult;
        startDiv  = doDiv;
        @(negedge clk);
        startMult = 1'b0;
        startDiv  = 1'b0;
        busyCnt = 0;
        n = 1;
        aborted = 1'b0;
        while (1) begin
            if (pokeAt != 0 && n == pokeAt) begin
                if (pokeReset) begin
                    reset = 1'b1;
                    #1;
                    chk("reset_busy", {63'd0, busy}, 64'd0);
                    chk("reset_done", {63'd0, done}, 64'd0);
                    chk("reset_hi", {32'd0, hi}, 64'd0);
                    chk("reset_lo", {32'd0, lo}, 64'd0);
                    sb.delete();
                    repeat (3) @(negedge clk);
                    reset = 1'b0;
                    aborted = 1'b1;
                    break;
                end else begin
                    startDiv = 1'b1;
                    a = 32'd1000;
                    b = 32'd3;
                end
            end
            if (pokeAt != 0 && n == pokeAt + 1) startDiv = 1'b0;
            if (busy) busyCnt++;
            if (sb.size() == 0) break;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL timeout: got no event after %0d cycles, required one", n);
                sb.delete();
                break;
            end
            @(negedge clk);
        end
        if (!aborted) chk("busy_cycles", 64'(busyCnt), e.isZero ? 64'd0 : 64'd33);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_div_zero", {63'd0, divZero}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        runOp(1, 0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0);
        runOp(1, 0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 0);
        runOp(0, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0);
        runOp(0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 0);
        runOp(0, 1, 32'd100, 32'd7, 32'd2, 32'd14, 0, 0);
        runOp(0, 1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 0, 0);
        runOp(1, 0, 32'd5, 32'd6, 32'd0, 32'd30, 0, 0);
        runOp(0, 1, 32'd123, 32'd0, 32'd0, 32'd30, 0, 0);
        runOp(1, 0, 32'd100, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFF38, 10, 0);
        runOp(1, 1, 32'hFFFFFFFB, 32'd9, 32'hFFFFFFFF, 32'hFFFFFFD3, 0, 0);
        runOp(0, 1, 32'd1000, 32'd3, 32'd1, 32'd333, 15, 1);
        @(negedge clk);
        runOp(1, 0, 32'd3, 32'd4, 32'd0, 32'd12, 0, 0);

        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_ctrl.md
# mult_div_ctrl

Multicycle multiply/divide sequencer for the MIPS CPU. It owns the HI and LO registers and runs signed 32x32 multiply and signed 32/32 divide iteratively. The main control FSM starts it with `multControl`/`divControl`-style pulses, holds in a wait state while `busy` is high, and resumes on `done`. A divide by zero is reported to the exception path as a one-cycle `div_zero` pulse.

## Interface

Parameters:
- `ITER`, default 32: number of iteration cycles. Fixed equal to the data width; not meant for override.

Ports:
- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start_mult`  in  1: one-cycle request for signed multiply `a*b`.
- `start_div`  in  1: one-cycle request for signed divide `a/b`.
- `a`  in  32: operand (rs, register A). Sampled only on the start edge.
- `b`  in  32: operand (rt, register B). Sampled only on the start edge.
- `busy`  out  1: an operation is in progress. Start requests are ignored while it is high.
- `done`  out  1: one-cycle pulse; HI/LO hold the new result.
- `div_zero`  out  1: one-cycle pulse; divide with `b==0` was rejected.
- `hi`  out  32: HI register.
- `lo`  out  32: LO register.

## Operation

- States: IDLE, MULT, DIV, FIX, DONE.
- IDLE:
  - `start_mult` → latch |a|, |b| and the result sign (a[31]^b[31]); clear the 64-bit accumulator; go to MULT.
  - `start_div` with `b!=0` → latch |a|, |b|, the quotient sign (a[31]^b[31]) and the remainder sign (a[31]); go to DIV.
  - `start_div` with `b==0` → pulse `div_zero` in the next cycle; stay IDLE; `hi`/`lo` unchanged.
  - Both starts high in the same cycle → multiply wins; `start_div` is dropped.
- MULT: unsigned shift-add, one multiplier bit per cycle, LSB first, for `ITER` cycles. The 5-bit iteration counter counts down from 31. Leave to FIX when the counter is 0.
- DIV: unsigned restoring divide, one quotient bit per cycle, MSB first, for `ITER` cycles. Same counter rule as MULT.
- FIX: apply sign correction and write HI/LO; go to DONE.
  - mult: two's-complement negate the full 64-bit product if the sign is set. `hi` = product[63:32], `lo` = product[31:0].
  - div: `lo` = quotient, negated if the quotient sign is set. `hi` = remainder, negated if the remainder sign is set. Quotient truncates toward zero; the remainder takes the dividend's sign.
- DONE: `done`=1; go to IDLE. A start asserted during DONE is ignored; the control FSM issues starts only from IDLE.
- Width rules:
  - Magnitudes are held in 33 bits so |0x80000000| is exact.
  - 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0 (wraps, no trap).
- HI/LO change only in FIX. They are not written on `div_zero` and not written on an aborted operation.
- Start inputs seen while `busy` is high are ignored and not queued.

## Timing

- Reset values: `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0; state IDLE; all internal registers 0.
- Reset asserted mid-operation aborts immediately. HI/LO go to 0 and no `done` is issued.
- Let E0 be the rising edge that samples a start:
  - `busy` is high in the cycles after E0 through E33.
  - The iterations occupy edges E1..E32.
  - FIX writes HI/LO at E33.
  - `done` is high in the cycle after E33, with `busy` low in that cycle.
  - Total: 34 cycles from the start edge to `done`.
- `div_zero` is high in the cycle after E0 only; `busy` never rises for that request.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- Shared package `mult_div_pkg`:
  - state encoding: IDLE=0, MULT=1, DIV=2, FIX=3, DONE=4 (3 bits);
  - `ITER`=32;
  - the op-select constants used by the control FSM.
- A single module is sufficient. The add/subtract step may be a `mult_div_step` sub-module (33-bit adder/subtractor plus shift) if it eases reuse; it is not required.

## Test plan

- mult a=7, b=0xFFFFFFFD (-3) → `done` 34 cycles after the start edge; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `busy` high for exactly 33 cycles.
- mult a=b=0x80000000 → `hi`=0x40000000, `lo`=0x00000000.
- div a=0xFFFFFFF9 (-7), b=2 → `lo`=0xFFFFFFFD (-3), `hi`=0xFFFFFFFF (-1). Then div a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- div b=0 with `hi`/`lo` preloaded from a prior mult → `div_zero` pulses one cycle after the start, `busy` stays 0, `hi`/`lo` unchanged, no `done`.
- Start mult, pulse `start_div` at cycle 10 → ignored; the mult result is correct at cycle 34. Then assert `start_mult` and `start_div` together in IDLE → multiply executes.
- Start div, assert `reset` at cycle 15 → `busy`/`hi`/`lo`=0 immediately and no `done`. After reset releases, a new mult 3*4 gives `lo`=12, `hi`=0.
